// File: rtl/multicycle_sequencer.sv
// Multi-cycle ARM instruction sequencer: PC, fetch/data handshakes, stage strobes, retire count, timeout fault.
// Optional SEQ_SINGLE_STEP_EN adds a step input that gates every fetch from IDLE.
module multicycle_sequencer #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_RESET = '0,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                  step,
`endif
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [31:0]           imem_rdata,
    output logic [31:0]           instr,
    input  logic                  cond_pass,
    output logic                  dmem_req,
    output logic                  dmem_we,
    input  logic                  dmem_ready,
    output logic                  rf_read_en,
    output logic                  alu_en,
    output logic                  rf_we,
    output logic                  cpsr_we,
    output logic                  link_we,
    output logic [ADDR_WIDTH-1:0] link_data,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [2:0]            state,
    output logic                  retire,
    output logic [CNT_WIDTH-1:0]  retire_count,
    output logic                  fault
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
        FAULT     = 3'd7
    } seqState_e;

    localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    seqState_e              curState;
    logic                   annul;
    logic [WAIT_W-1:0]      waitCnt;
    logic [CNT_WIDTH-1:0]   retireCnt;

    logic                   isLdSt;
    logic                   isBranch;
    logic                   isDp;
    logic                   isCmp;
    logic                   wbLive;
    logic                   timeoutHit;
    logic signed [25:0]     brOff;
    logic [ADDR_WIDTH-1:0]  pcPlus4;
    logic [ADDR_WIDTH-1:0]  brTarget;

    assign isLdSt   = (instr[27:26] == 2'b01);
    assign isBranch = (instr[27:25] == 3'b101);
    assign isDp     = (instr[27:26] == 2'b00);
    assign isCmp    = isDp && (instr[24:23] == 2'b10);
    assign wbLive   = (curState == WRITEBACK) && !annul;

    // The counter only ever holds 0..TIMEOUT_CYCLES-1; the wait that would reach the limit faults instead.
    assign timeoutHit = (TIMEOUT_CYCLES != 0) && (32'(waitCnt) == TIMEOUT_CYCLES - 32'd1);

    assign brOff    = signed'({instr[23:0], 2'b00});
    assign pcPlus4  = pc + ADDR_WIDTH'(4);
    assign brTarget = pc + ADDR_WIDTH'(8) + ADDR_WIDTH'(brOff);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            curState  <= IDLE;
            pc        <= PC_RESET;
            instr     <= '0;
            retireCnt <= '0;
            annul     <= 1'b0;
            waitCnt   <= '0;
        end else begin
            case (curState)
                IDLE: begin
`ifdef SEQ_SINGLE_STEP_EN
                    if (run && step) begin
`else
                    if (run) begin
`endif
                        curState <= FETCH;
                        waitCnt  <= '0;
                    end
                end
                FETCH: begin
                    if (imem_ready) begin
                        instr    <= imem_rdata;
                        curState <= DECODE;
                    end else if (timeoutHit) begin
                        curState <= FAULT;
                    end else begin
                        waitCnt <= waitCnt + WAIT_W'(1);
                    end
                end
                DECODE: begin
                    annul    <= !cond_pass;
                    curState <= cond_pass ? EXECUTE : WRITEBACK;
                end
                EXECUTE: begin
                    if (isLdSt) begin
                        curState <= MEMORY;
                        waitCnt  <= '0;
                    end else begin
                        curState <= WRITEBACK;
                    end
                end
                MEMORY: begin
                    if (dmem_ready) begin
                        curState <= WRITEBACK;
                    end else if (timeoutHit) begin
                        curState <= FAULT;
                    end else begin
                        waitCnt <= waitCnt + WAIT_W'(1);
                    end
                end
                WRITEBACK: begin
                    pc        <= (!annul && isBranch) ? brTarget : pcPlus4;
                    retireCnt <= retireCnt + CNT_WIDTH'(1);
                    waitCnt   <= '0;
`ifdef SEQ_SINGLE_STEP_EN
                    curState  <= IDLE;
`else
                    curState  <= run ? FETCH : IDLE;
`endif
                end
                FAULT: begin
                    curState <= FAULT;
                end
                default: begin
                    curState <= IDLE;
                end
            endcase
        end
    end

    assign state        = curState;
    assign fault        = (curState == FAULT);
    assign imem_req     = (curState == FETCH);
    assign imem_addr    = pc;
    assign dmem_req     = (curState == MEMORY);
    assign dmem_we      = dmem_req && !instr[20];
    assign rf_read_en   = (curState == DECODE);
    assign alu_en       = (curState == EXECUTE);
    assign rf_we        = wbLive && ((isDp && !isCmp) || (isLdSt && instr[20]));
    assign cpsr_we      = wbLive && isDp && instr[20];
    assign link_we      = wbLive && isBranch && instr[24];
    assign link_data    = pcPlus4;
    assign retire       = (curState == WRITEBACK);
    assign retire_count = retireCnt;

endmodule
